// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared types and constants for the tick scheduler.
//   ch_state_t    : per-channel FSM state (IDLE, ARMED, RUN, DONE)
//   MODE_*        : channel mode encoding as carried on cfg_oneshot
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ch_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one programmable divider channel of the tick scheduler.
// Counts base ticks and emits a registered one-cycle tick every `div` base
// ticks, either periodically or once (then parks in DONE).
//   CLK_50      : clock
//   nRST        : async active-low reset
//   base_tick   : shared base-rate strobe
//   cfg_we      : accepted configuration for this channel (wins over base_tick)
//   cfg_div     : divide ratio, 0 = stop
//   cfg_oneshot : 1 = one-shot, 0 = periodic
//   cfg_start   : 1 = arm on accept, 0 = load idle
//   tick        : one-cycle enable pulse
//   busy        : channel ARMED or RUN
//   done        : one-shot channel has fired
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          CLK_50,
  input  logic          nRST,
  input  logic          base_tick,
  input  logic          cfg_we,
  input  logic [DW-1:0] cfg_div,
  input  logic          cfg_oneshot,
  input  logic          cfg_start,
  output logic          tick,
  output logic          busy,
  output logic          done
);

  ch_state_t     state, state_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic          mode, mode_nxt;
  logic          tick_nxt, busy_nxt, done_nxt;

  // state register (also carries the registered outputs)
  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      div   <= '0;
      cnt   <= '0;
      mode  <= MODE_PERIODIC;
      tick  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
      tick  <= tick_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // next-state: a config write aborts whatever the channel was doing and
  // swallows a coincident base_tick, so no pulse can come from that tick.
  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    tick_nxt  = 1'b0;
    if (cfg_we) begin
      div_nxt  = cfg_div;
      mode_nxt = cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
      cnt_nxt  = '0;
      if (cfg_div == '0)  state_nxt = IDLE;
      else if (cfg_start) state_nxt = ARMED;
      else                state_nxt = IDLE;
    end else if (base_tick) begin
      case (state)
        // div > 0 is guaranteed in ARMED/RUN, so div-1 cannot wrap
        ARMED: begin
          cnt_nxt   = div - DW'(1);
          state_nxt = RUN;
        end
        RUN: begin
          if (cnt == '0) begin
            tick_nxt = 1'b1;
            cnt_nxt  = div - DW'(1);
            if (mode == MODE_ONESHOT) state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // outputs: decoded from the next state so they register alongside it
  always_comb begin
    busy_nxt = (state_nxt == ARMED) || (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared timebase controller.
// A base prescaler divides CLK_50 down to BASE_FREQ; NCH channels each divide
// that base tick by a runtime-loaded ratio.
//   CLK_50      : clock
//   nRST        : async active-low reset
//   cfg_valid   : configuration request
//   cfg_ready   : slot available (drops for one cycle after each accept)
//   cfg_ch      : target channel (out-of-range channels are accepted, ignored)
//   cfg_div     : divide ratio in base ticks, 0 = stop
//   cfg_oneshot : 1 = one-shot, 0 = periodic
//   cfg_start   : 1 = arm on accept, 0 = load idle
//   base_tick   : one-cycle pulse at BASE_FREQ
//   tick        : per-channel one-cycle enable pulses
//   busy        : per-channel ARMED or RUN
//   done        : per-channel one-shot fired, held until reconfigured
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BASE_FREQ = 1000,
  parameter int NCH       = 4,
  parameter int DW        = 16,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK_50,
  input  logic           nRST,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  input  logic           cfg_oneshot,
  input  logic           cfg_start,
  output logic           base_tick,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done
);

  localparam int PRE = CLK_FREQ / BASE_FREQ;
  localparam int PW  = $clog2(PRE);

  logic [PW-1:0] pre_cnt;
  logic          pre_wrap;
  logic          accept;

  assign pre_wrap = (pre_cnt == PW'(PRE - 1));
  assign accept   = cfg_valid && cfg_ready;

  // free-running prescaler; configuration never touches it
  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else begin
      pre_cnt   <= pre_wrap ? '0 : pre_cnt + PW'(1);
      base_tick <= pre_wrap;
    end
  end

  // one dead cycle after every accept caps the rate at one per two cycles
  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) cfg_ready <= 1'b1;
    else       cfg_ready <= !accept;
  end

  // channel decode: a cfg_ch with no matching channel selects nothing
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_channel #(.DW(DW)) u_ch (
      .CLK_50      (CLK_50),
      .nRST        (nRST),
      .base_tick   (base_tick),
      .cfg_we      (accept && (cfg_ch == CW'(i))),
      .cfg_div     (cfg_div),
      .cfg_oneshot (cfg_oneshot),
      .cfg_start   (cfg_start),
      .tick        (tick[i]),
      .busy        (busy[i]),
      .done        (done[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a prescale of 10 (1000/100).
// cyc counts rising edges since reset release; outputs are sampled on the
// falling edge, so "cycle n" is the value registered by rising edge n.
module tb_tick_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic           CLK_50 = 1'b0;
  logic           nRST;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic           cfg_oneshot;
  logic           cfg_start;
  logic           base_tick;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;

  int checks   = 0;
  int failures = 0;
  int cyc;

  tick_scheduler #(
    .CLK_FREQ (1000),
    .BASE_FREQ(100),
    .NCH      (NCH),
    .DW       (DW)
  ) dut (
    .CLK_50     (CLK_50),
    .nRST       (nRST),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_oneshot(cfg_oneshot),
    .cfg_start  (cfg_start),
    .base_tick  (base_tick),
    .tick       (tick),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK_50 = ~CLK_50;

  always @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic nxt;
    @(negedge CLK_50);
  endtask

  task automatic cfg_drive(input logic v, input logic [1:0] ch, input logic [DW-1:0] dv,
                           input logic os, input logic st);
    cfg_valid   = v;
    cfg_ch      = ch;
    cfg_div     = dv;
    cfg_oneshot = os;
    cfg_start   = st;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    cfg_drive(1'b0, 2'd0, '0, 1'b0, 1'b0);
    repeat (3) nxt;
    checks++;
    if ({cfg_ready, base_tick, tick, busy, done} !== {1'b1, 1'b0, 12'b0}) begin
      failures++;
      $display("FAIL reset_vals got=%0b exp=%0b", {cfg_ready, base_tick, tick, busy, done},
               {1'b1, 1'b0, 12'b0});
    end
    nRST = 1'b1;
    while (cyc < 35) begin
      nxt;
      checks++;
      if (base_tick !== (cyc % 10 == 0)) begin
        failures++;
        $display("FAIL rst_base_tick cyc=%0d got=%0b exp=%0b", cyc, base_tick, (cyc % 10 == 0));
      end
      checks++;
      if ({cfg_ready, tick, busy, done} !== {1'b1, 12'b0}) begin
        failures++;
        $display("FAIL rst_idle_outs cyc=%0d got=%0b exp=%0b", cyc, {cfg_ready, tick, busy, done},
                 {1'b1, 12'b0});
      end
    end
  endtask

  // ch0 div=3 periodic, accepted at edge 36; arming tick is base cycle 40,
  // so pulses land at 71, 101, 131
  task automatic test_periodic;
    cfg_drive(1'b1, 2'd0, 16'd3, 1'b0, 1'b1);
    nxt;
    cfg_valid = 1'b0;
    checks++;
    if ({busy[0], cfg_ready} !== 2'b10) begin
      failures++;
      $display("FAIL per_accept cyc=%0d got=%0b exp=10", cyc, {busy[0], cfg_ready});
    end
    while (cyc < 135) begin
      nxt;
      checks++;
      if (tick[0] !== (cyc >= 71 && cyc % 30 == 11)) begin
        failures++;
        $display("FAIL per_tick0 cyc=%0d got=%0b exp=%0b", cyc, tick[0], (cyc >= 71 && cyc % 30 == 11));
      end
      checks++;
      if ({busy[0], cfg_ready} !== 2'b11) begin
        failures++;
        $display("FAIL per_busy_rdy cyc=%0d got=%0b exp=11", cyc, {busy[0], cfg_ready});
      end
    end
  endtask

  // ch1 div=2 one-shot accepted at edge 136: single pulse at 161, then DONE
  task automatic test_oneshot;
    cfg_drive(1'b1, 2'd1, 16'd2, 1'b1, 1'b1);
    while (cyc < 200) begin
      nxt;
      if (cyc == 136) cfg_valid = 1'b0;
      checks++;
      if (tick[1] !== (cyc == 161)) begin
        failures++;
        $display("FAIL os_tick1 cyc=%0d got=%0b exp=%0b", cyc, tick[1], (cyc == 161));
      end
      checks++;
      if ({busy[1], done[1]} !== {(cyc < 161), (cyc >= 161)}) begin
        failures++;
        $display("FAIL os_busy_done cyc=%0d got=%0b exp=%0b", cyc, {busy[1], done[1]},
                 {(cyc < 161), (cyc >= 161)});
      end
      checks++;
      if (tick[0] !== (cyc % 30 == 11)) begin
        failures++;
        $display("FAIL os_tick0 cyc=%0d got=%0b exp=%0b", cyc, tick[0], (cyc % 30 == 11));
      end
    end
    cfg_drive(1'b1, 2'd1, 16'd0, 1'b0, 1'b0);
    nxt;
    cfg_valid = 1'b0;
    checks++;
    if ({busy[1], done[1]} !== 2'b00) begin
      failures++;
      $display("FAIL os_reconfig_clear cyc=%0d got=%0b exp=00", cyc, {busy[1], done[1]});
    end
  endtask

  // ch2 div=1 accepted at edge 211 while base_tick is high: that tick is
  // swallowed (no pulse at 221), first pulse at 231. Valid stays high for
  // two more accepts to ch3 (div=0) at edges 213 and 215.
  task automatic test_back_to_back;
    while (cyc < 210) nxt;
    checks++;
    if (base_tick !== 1'b1) begin
      failures++;
      $display("FAIL b2b_base_tick cyc=%0d got=%0b exp=1", cyc, base_tick);
    end
    cfg_drive(1'b1, 2'd2, 16'd1, 1'b0, 1'b1);
    while (cyc < 255) begin
      nxt;
      if (cyc == 211) cfg_drive(1'b1, 2'd3, 16'd0, 1'b0, 1'b0);
      if (cyc == 215) cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== (cyc > 216 || cyc % 2 == 0)) begin
        failures++;
        $display("FAIL b2b_ready cyc=%0d got=%0b exp=%0b", cyc, cfg_ready, (cyc > 216 || cyc % 2 == 0));
      end
      checks++;
      if (tick[2] !== (cyc >= 231 && cyc % 10 == 1)) begin
        failures++;
        $display("FAIL b2b_tick2 cyc=%0d got=%0b exp=%0b", cyc, tick[2], (cyc >= 231 && cyc % 10 == 1));
      end
      checks++;
      if ({busy[3], busy[2]} !== 2'b01) begin
        failures++;
        $display("FAIL b2b_busy cyc=%0d got=%0b exp=01", cyc, {busy[3], busy[2]});
      end
      checks++;
      if (tick[0] !== (cyc % 30 == 11)) begin
        failures++;
        $display("FAIL b2b_tick0 cyc=%0d got=%0b exp=%0b", cyc, tick[0], (cyc % 30 == 11));
      end
    end
  endtask

  // ch0 last pulsed at 251 (cnt reload 2), so cnt==1 during 261..270
  task automatic test_reset_mid;
    while (cyc < 265) nxt;
    checks++;
    if (busy !== 4'b0101) begin
      failures++;
      $display("FAIL mid_busy_pre cyc=%0d got=%0b exp=0101", cyc, busy);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({cfg_ready, base_tick, tick, busy, done} !== {1'b1, 1'b0, 12'b0}) begin
      failures++;
      $display("FAIL mid_async_clear got=%0b exp=%0b", {cfg_ready, base_tick, tick, busy, done},
               {1'b1, 1'b0, 12'b0});
    end
    repeat (3) nxt;
    nRST = 1'b1;
    while (cyc < 45) begin
      nxt;
      checks++;
      if ({tick, busy, done} !== 12'b0) begin
        failures++;
        $display("FAIL mid_quiet cyc=%0d got=%0b exp=0", cyc, {tick, busy, done});
      end
      checks++;
      if (base_tick !== (cyc % 10 == 0)) begin
        failures++;
        $display("FAIL mid_base_tick cyc=%0d got=%0b exp=%0b", cyc, base_tick, (cyc % 10 == 0));
      end
    end
    // ch0 div=1 accepted at edge 46: RUN after base cycle 50, pulses 61, 71
    cfg_drive(1'b1, 2'd0, 16'd1, 1'b0, 1'b1);
    while (cyc < 72) begin
      nxt;
      if (cyc == 46) cfg_valid = 1'b0;
      checks++;
      if (tick !== {3'b000, (cyc == 61 || cyc == 71)}) begin
        failures++;
        $display("FAIL mid_div1_tick cyc=%0d got=%0b exp=%0b", cyc, tick, {3'b000, (cyc == 61 || cyc == 71)});
      end
      checks++;
      if (busy !== 4'b0001) begin
        failures++;
        $display("FAIL mid_div1_busy cyc=%0d got=%0b exp=0001", cyc, busy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_periodic;
    test_oneshot;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared timebase controller for the 50 MHz board clock. One base prescaler produces a `BASE_FREQ` tick that NCH programmable channels share. Each channel divides the base tick by a runtime-loaded ratio and emits single-cycle tick-enable pulses, either periodic or one-shot. It replaces per-rate free-running toggle dividers and feeds enables to display, debounce and stopwatch logic.

## Interface
- `CLK_FREQ`, 50000000: input clock frequency in Hz.
- `BASE_FREQ`, 1000: base tick rate in Hz. `CLK_FREQ/BASE_FREQ` must be an integer of at least 2.
- `NCH`, 4: number of channels, 1..8.
- `DW`, 16: width of the divide ratio.
- `CLK_50`  in  1: clock, rising-edge.
- `nRST`  in  1: asynchronous, active-low reset.
- `cfg_valid`  in  1: configuration request.
- `cfg_ready`  out  1: configuration slot available.
- `cfg_ch`  in  max(1,$clog2(NCH)): target channel.
- `cfg_div`  in  DW: divide ratio in base ticks. 0 means stop.
- `cfg_oneshot`  in  1: 1 selects one-shot mode, 0 selects periodic.
- `cfg_start`  in  1: 1 arms the channel on accept, 0 loads it idle.
- `base_tick`  out  1: one-cycle pulse at BASE_FREQ.
- `tick`  out  NCH: per-channel one-cycle enable pulses.
- `busy`  out  NCH: channel is ARMED or RUN.
- `done`  out  NCH: one-shot channel has fired, held until reconfigured.

## Operation
- Prescaler width `PW = $clog2(CLK_FREQ/BASE_FREQ)`. It counts `0..CLK_FREQ/BASE_FREQ-1` and wraps.
- `base_tick` is registered. It is high for the one cycle after the count wraps.
- The prescaler always runs while `nRST` is high. Configuration never resets it.
- Config handshake:
  - A request is accepted when `cfg_valid && cfg_ready`.
  - `cfg_ready` goes low for exactly the cycle after an accept, then returns high. Maximum rate is one accept per 2 cycles.
  - Inputs only need to be stable in the accept cycle.
- On accept, the target channel latches `div`, `oneshot` and `done<=0`:
  - `cfg_div==0`: next state IDLE.
  - else if `cfg_start`: next state ARMED.
  - else: next state IDLE with the ratio stored.
- If `cfg_ch >= NCH`, the request is accepted and ignored.
- Channel FSM. All transitions below other than the config transitions happen only in cycles where `base_tick` is high.
  - IDLE: `tick` is held 0. It leaves only via config.
  - ARMED: on `base_tick`, set `cnt<=div-1` and go to RUN. No pulse.
  - RUN: on `base_tick`, if `cnt==0`, pulse `tick` next cycle and reload `cnt<=div-1`. A one-shot channel then goes to DONE. Otherwise `cnt<=cnt-1`.
  - DONE: `done` is 1 and `tick` is 0. It leaves only via config.
- Resulting tick spacing is `div` base ticks. With `div=1`, the channel pulses on every base tick after arming.
- Reconfiguring a channel in any state aborts it immediately. Its count is discarded and the new configuration applies from the next cycle.

## Timing
- Reset values: `cfg_ready=1`, `base_tick=0`, `tick=0`, `busy=0`, `done=0`. All channels are IDLE, `div=0`, `cnt=0`, prescaler at 0.
- First `base_tick` rises `CLK_FREQ/BASE_FREQ` cycles after `nRST` deasserts.
- `tick[i]` rises 1 cycle after the qualifying `base_tick` cycle. It never overlaps the same `base_tick` pulse.
- `busy` and `done` update 1 cycle after the causing event.
- Config accept in the same cycle as `base_tick`:
  - The configuration wins for the target channel. That `base_tick` is ignored by it and no pulse is produced.
  - Other channels process the `base_tick` normally.
- A pulse already registered for the following cycle still appears, even if the channel is reconfigured in that cycle.
- Asserting `nRST` mid-operation clears everything asynchronously. No pending pulse survives.
- `cnt` is DW bits. `div-1` never underflows because `div>0` is guaranteed in ARMED and RUN.

## Structure
- `tick_sched_pkg` holds:
  - the channel state enum (IDLE, ARMED, RUN, DONE, 2 bits);
  - the mode constants `MODE_PERIODIC=0` and `MODE_ONESHOT=1`.
- Sub-module `tick_channel` contains one channel's FSM, `div` and `cnt` registers and the `tick`/`busy`/`done` registers. It is instantiated NCH times in a generate loop.
- The top level holds the prescaler, the config handshake and the channel decode.

## Test plan
All scenarios use `CLK_FREQ=1000`, `BASE_FREQ=100`, giving a prescale of 10.
- Reset release: `base_tick` pulses at cycles 10, 20, 30. All other outputs stay 0 and `cfg_ready` stays 1.
- Configure ch0 with `div=3`, periodic, start:
  - `busy[0]` goes to 1 one cycle after accept.
  - `tick[0]` pulses 3 `base_tick`s after the arming tick, then every 30 cycles.
- Configure ch1 with `div=2`, one-shot: exactly one `tick[1]`, after which `done[1]=1` and `busy[1]=0`. Reconfigure with `div=0`: `done[1]` clears.
- Accept for ch2 in a `base_tick` cycle:
  - No `tick[2]` from that base tick.
  - ch0 still ticks on schedule.
  - `cfg_valid` held high gives accepts spaced exactly 2 cycles apart.
- Drop `nRST` while ch0 is RUN with `cnt=1`: all outputs are 0 immediately, and after release no tick appears until ch0 is reconfigured.
